// File: rtl/hazard3_branch_predictor.sv
// hazard3_branch_predictor
//  Direct-mapped branch target buffer with 2-bit saturating direction counters.
//  Execute reports resolved conditional branches on the upd_* port. Fetch looks
//  up its PC on the lookup_* port and gets a registered prediction one cycle
//  later. flush_req walks every entry invalid, one entry per cycle.
//
// Parameters
//  W_ADDR     address width (PC and target)
//  N_ENTRIES  number of BTB entries, power of 2, >= 2
//  IDX_LSB    lowest PC bit used for indexing (1 = halfword aligned)
//
// Ports
//  clk, rst_n                  clock, asynchronous active-low reset
//  lookup_vld, lookup_pc       fetch lookup request
//  pred_vld, pred_taken,       registered prediction; pred_target is 0 when
//  pred_target                 pred_taken is 0
//  upd_vld, upd_pc,            resolved branch from execute
//  upd_target, upd_taken
//  flush_req                   invalidate all entries (restarts an active walk)
//  busy                        flush walk in progress
//
// Optional feature: define HAZARD3_BP_STATIC_BTFN_EN to add lookup_static_target
//  and lookup_is_bwd. On a BTB miss outside a flush, a backward branch is then
//  predicted taken towards lookup_static_target.

module hazard3_branch_predictor #(
  parameter int unsigned W_ADDR    = 32,
  parameter int unsigned N_ENTRIES = 8,
  parameter int unsigned IDX_LSB   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_vld,
  input  logic [W_ADDR-1:0] lookup_pc,
  output logic              pred_vld,
  output logic              pred_taken,
  output logic [W_ADDR-1:0] pred_target,
  input  logic              upd_vld,
  input  logic [W_ADDR-1:0] upd_pc,
  input  logic [W_ADDR-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              flush_req,
`ifdef HAZARD3_BP_STATIC_BTFN_EN
  input  logic [W_ADDR-1:0] lookup_static_target,
  input  logic              lookup_is_bwd,
`endif
  output logic              busy
);

  localparam int unsigned W_IDX = $clog2(N_ENTRIES);
  localparam int unsigned W_TAG = W_ADDR - IDX_LSB - W_IDX;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t             state_q, state_nxt;
  logic [W_IDX-1:0]   ptr_q, ptr_nxt;

  logic               valid_q  [N_ENTRIES];
  logic [W_TAG-1:0]   tag_q    [N_ENTRIES];
  logic [W_ADDR-1:0]  target_q [N_ENTRIES];
  logic [1:0]         ctr_q    [N_ENTRIES];

  logic [W_IDX-1:0]   lk_idx, upd_idx;
  logic [W_TAG-1:0]   lk_tag, upd_tag;
  logic               lk_hit, upd_hit;
  logic               nxt_taken;
  logic [W_ADDR-1:0]  nxt_target;

  // Bits below IDX_LSB never reach the table.
  generate
    if (IDX_LSB > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^{lookup_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};
    end
  endgenerate

  assign busy = (state_q == S_FLUSH);

  // ---------------------------------------------------------------------------
  // Flush walk FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          state_nxt = S_FLUSH;
          ptr_nxt   = '0;
        end
      end
      S_FLUSH: begin
        // A repeated request restarts the walk, even on the last entry.
        if (flush_req) begin
          ptr_nxt = '0;
        end else if (ptr_q == W_IDX'(N_ENTRIES - 1)) begin
          state_nxt = S_IDLE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr_q + W_IDX'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Table read (lookup and update both read the registered state, so a
  // same-cycle lookup sees the pre-update entry)
  // ---------------------------------------------------------------------------
  always_comb begin
    lk_idx  = lookup_pc[IDX_LSB +: W_IDX];
    lk_tag  = lookup_pc[W_ADDR-1 : IDX_LSB+W_IDX];
    lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    upd_idx = upd_pc[IDX_LSB +: W_IDX];
    upd_tag = upd_pc[W_ADDR-1 : IDX_LSB+W_IDX];
    upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  end

  always_comb begin
    nxt_taken  = 1'b0;
    nxt_target = '0;
    if (lookup_vld && state_q == S_IDLE) begin
      if (lk_hit) begin
        nxt_taken  = ctr_q[lk_idx][1];
        nxt_target = ctr_q[lk_idx][1] ? target_q[lk_idx] : '0;
      end
`ifdef HAZARD3_BP_STATIC_BTFN_EN
      else if (lookup_is_bwd) begin
        nxt_taken  = 1'b1;
        nxt_target = lookup_static_target;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_vld    <= lookup_vld;
      pred_taken  <= nxt_taken;
      pred_target <= nxt_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Table write: flush walk has priority; updates are dropped while flushing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (state_q == S_FLUSH) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (upd_vld) begin
      if (upd_hit) begin
        target_q[upd_idx] <= upd_target;
        if (upd_taken) begin
          ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
        end else begin
          ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_hazard3_branch_predictor.sv
module tb_hazard3_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_vld;
  logic [31:0] lookup_pc;
  logic        pred_vld;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_vld;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        flush_req;
  logic        busy;
`ifdef HAZARD3_BP_STATIC_BTFN_EN
  logic [31:0] lookup_static_target;
  logic        lookup_is_bwd;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard3_branch_predictor #(
    .W_ADDR    (32),
    .N_ENTRIES (8),
    .IDX_LSB   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_vld  (lookup_vld),
    .lookup_pc   (lookup_pc),
    .pred_vld    (pred_vld),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_vld     (upd_vld),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .flush_req   (flush_req),
`ifdef HAZARD3_BP_STATIC_BTFN_EN
    .lookup_static_target (lookup_static_target),
    .lookup_is_bwd        (lookup_is_bwd),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    upd_vld    = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = tk;
    tick();
    upd_vld    = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [31:0] pc,
                           input logic exp_taken, input logic [31:0] exp_tgt);
    lookup_vld = 1'b1;
    lookup_pc  = pc;
    tick();
    lookup_vld = 1'b0;
    check({tag, ".vld"},    32'(pred_vld),   32'd1);
    check({tag, ".taken"},  32'(pred_taken), 32'(exp_taken));
    check({tag, ".target"}, pred_target,     exp_tgt);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; lookup_vld = 1'b0; lookup_pc = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush_req = 1'b0;
`ifdef HAZARD3_BP_STATIC_BTFN_EN
    lookup_static_target = '0; lookup_is_bwd = 1'b0;
`endif
    #23;
    check("rst.pred_vld",    32'(pred_vld),   32'd0);
    check("rst.pred_taken",  32'(pred_taken), 32'd0);
    check("rst.pred_target", pred_target,     32'd0);
    check("rst.busy",        32'(busy),       32'd0);
    rst_n = 1'b1;
    tick();

    // 1: empty table
    do_lookup("t1.cold", 32'h100, 1'b0, 32'h0);
    tick();
    check("t1.idle_vld", 32'(pred_vld), 32'd0);

    // 2: allocation and counter saturation
    do_upd(32'h100, 32'h80, 1'b1);                   // ctr 2
    do_lookup("t2.alloc", 32'h100, 1'b1, 32'h80);
    do_upd(32'h100, 32'h80, 1'b0);                   // ctr 1
    do_lookup("t2.ctr1", 32'h100, 1'b0, 32'h0);
    do_upd(32'h100, 32'h80, 1'b0);                   // ctr 0
    do_upd(32'h100, 32'h80, 1'b0);                   // stays 0
    do_lookup("t2.sat0", 32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) do_upd(32'h100, 32'h80, 1'b1); // 0->3, stays 3
    do_lookup("t2.sat3", 32'h100, 1'b1, 32'h80);
    do_upd(32'h100, 32'h80, 1'b0);                   // ctr 2
    do_lookup("t2.ctr2", 32'h100, 1'b1, 32'h80);
    do_upd(32'h100, 32'h90, 1'b0);                   // ctr 1, target rewritten
    do_upd(32'h100, 32'h90, 1'b1);                   // ctr 2
    do_lookup("t2.retgt", 32'h100, 1'b1, 32'h90);

    // 3: conflicting tag at index 0 replaces the entry
    do_upd(32'h110, 32'h200, 1'b1);
    do_lookup("t3.old_miss", 32'h100, 1'b0, 32'h0);
    do_lookup("t3.new_hit",  32'h110, 1'b1, 32'h200);
    do_upd(32'h100, 32'h80, 1'b0);                   // not-taken miss: no write
    do_lookup("t3.nt_nowr",  32'h110, 1'b1, 32'h200);

    // 4: same-cycle lookup and update read the old entry
    do_upd(32'h100, 32'h80, 1'b1);                   // replace, ctr 2
    lookup_vld = 1'b1; lookup_pc = 32'h100;
    upd_vld = 1'b1; upd_pc = 32'h100; upd_target = 32'h80; upd_taken = 1'b0;
    tick();
    lookup_vld = 1'b0; upd_vld = 1'b0;
    check("t4.rbw.taken",  32'(pred_taken), 32'd1);
    check("t4.rbw.target", pred_target,     32'h80);
    do_lookup("t4.after", 32'h100, 1'b0, 32'h0);

    // 5: fill, flush, update dropped during flush
    for (int i = 0; i < 8; i++) do_upd(32'h100 + 32'(2 * i), 32'h1000 + 32'(16 * i), 1'b1);
    do_lookup("t5.fill5", 32'h10A, 1'b1, 32'h1050);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 6) begin
        upd_vld = 1'b1; upd_pc = 32'h108; upd_target = 32'h5000; upd_taken = 1'b1;
      end else begin
        upd_vld = 1'b0;
      end
      tick();
    end
    upd_vld = 1'b0;
    check("t5.busy_cycles", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) do_lookup("t5.post_miss", 32'h100 + 32'(2 * i), 1'b0, 32'h0);

    // 5b: lookup during flush, restart at walk cycle 3
    do_upd(32'h10E, 32'h77, 1'b1);
    do_lookup("t5.refill", 32'h10E, 1'b1, 32'h77);
    flush_req = 1'b1;
    tick();                                          // walk cycle 0
    flush_req = 1'b0;
    lookup_vld = 1'b1; lookup_pc = 32'h10E;
    tick();                                          // walk cycle 1
    lookup_vld = 1'b0;
    check("t5.flush_lk.vld",   32'(pred_vld),   32'd1);
    check("t5.flush_lk.taken", 32'(pred_taken), 32'd0);
    tick();                                          // walk cycle 2
    tick();                                          // walk cycle 3
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check("t5.restart_cycles", 32'(n), 32'd8);
    do_lookup("t5.restart_miss", 32'h10E, 1'b0, 32'h0);

`ifdef HAZARD3_BP_STATIC_BTFN_EN
    // 6: static backward-taken on a miss, overridden by a BTB hit
    lookup_is_bwd = 1'b1; lookup_static_target = 32'h40;
    do_lookup("t6.static", 32'h200, 1'b1, 32'h40);
    do_upd(32'h200, 32'h40, 1'b1);                   // ctr 2
    do_upd(32'h200, 32'h40, 1'b0);                   // ctr 1
    do_lookup("t6.override", 32'h200, 1'b0, 32'h0);
    lookup_is_bwd = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
